// File: rtl/cla_pkg.sv
// Shared types for the carry-lookahead adder: group width and the
// generate/propagate pair passed from each 4-bit group to the second level.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    typedef struct packed {
        logic g;    // group generates a carry regardless of carry-in
        logic p;    // group passes its carry-in straight through
    } cla_gp_t;

endpackage

// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder. The ovf signal exists only when
// CLA_OVERFLOW_EN is defined.
interface cla_adder_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVERFLOW_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, input out_valid, sum, cout, ovf);
    modport slave  (input in_valid, a, b, cin, output out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, input out_valid, sum, cout);
    modport slave  (input in_valid, a, b, cin, output out_valid, sum, cout);
`endif

endinterface

// File: rtl/cla_group4.sv
// First-level 4-bit lookahead group: internal carries from the group
// carry-in, the group sum, and the group generate/propagate pair.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_GROUP_W-1:0] sum,
    output cla_gp_t                gp
);

    logic [CLA_GROUP_W-1:0] g;
    logic [CLA_GROUP_W-1:0] p;
    logic [CLA_GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Internal carries as flat sum-of-products of g/p and the group carry-in
    always_comb begin
        c    = '0;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
    end

    // Group G/P depend only on the operands, never on the carry-in, so the
    // second level can resolve all group carries without a loop back here
    always_comb begin
        gp   = '0;
        gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp.p = &p;
    end

endmodule

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder. WIDTH/4 lookahead groups feed a
// second-level unit that forms every group carry-in directly from lower
// group G/P and cin; results are registered on in_valid, else held.
// Optional feature macro: CLA_OVERFLOW_EN adds the registered signed
// overflow output ovf.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cla_adder_if.slave   bus
);

    localparam int NG = WIDTH / CLA_GROUP_W;

    cla_gp_t [NG-1:0] gp;
    logic    [NG:0]   c_grp;
    logic [WIDTH-1:0] sum_c;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             out_valid_d, out_valid_q;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group4 u_grp (
            .a   (bus.a[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .b   (bus.b[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin (c_grp[gi]),
            .sum (sum_c[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .gp  (gp[gi])
        );
    end

    // Carry into group k: OR over j<k of G[j] & P[j+1..k-1], plus cin & P[0..k-1].
    // Each carry is its own product-of-terms, no chaining through c_grp.
    function automatic logic grp_carry(input cla_gp_t [NG-1:0] gpv, input logic c0, input int k);
        logic c;
        logic t;
        c = c0;
        for (int i = 0; i < k; i++) c = c & gpv[i].p;
        for (int j = 0; j < k; j++) begin
            t = gpv[j].g;
            for (int i = j + 1; i < k; i++) t = t & gpv[i].p;
            c = c | t;
        end
        return c;
    endfunction

    // Second-level lookahead: all group carry-ins and the final carry-out
    always_comb begin
        c_grp = '0;
        for (int k = 0; k <= NG; k++) c_grp[k] = grp_carry(gp, bus.cin, k);
    end

    // Next-state: capture a fresh result only on in_valid, otherwise hold
    always_comb begin
        out_valid_d = bus.in_valid;
        sum_d       = bus.in_valid ? sum_c      : sum_q;
        cout_d      = bus.in_valid ? c_grp[NG]  : cout_q;
    end

    // Output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;

`ifdef CLA_OVERFLOW_EN
    logic c_msb;
    logic ovf_d, ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c
    always_comb begin
        c_msb = bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ sum_c[WIDTH-1];
        ovf_d = bus.in_valid ? (c_msb ^ c_grp[NG]) : ovf_q;
    end

    // Overflow flag registered alongside sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder: WIDTH=4 and WIDTH=16 instances side by side, a
// directed vector table, hold/reset sequences, then an exhaustive 4-bit sweep
// alongside random 16-bit traffic checked against an arithmetic model.
module tb_cla_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cla_adder_if #(.WIDTH(4))  if4 ();
    cla_adder_if #(.WIDTH(16)) if16 ();

    cla_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    cla_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int tests = 0;
    int fails = 0;

    // Model state per instance: 0 -> WIDTH 4, 1 -> WIDTH 16
    logic [31:0] e_sum  [2];
    logic        e_cout [2];
    logic        e_ovf  [2];
    logic        e_vld  [2];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add, using plain integer arithmetic
    function automatic logic [33:0] ref_add(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit ci);
        longint unsigned m;
        longint unsigned full;
        longint          sa, sb, r, half;
        logic            ov;
        m    = 64'd1 << w;
        half = longint'(m / 2);
        full = a + b + longint'(ci);
        sa   = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
        sb   = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
        r    = sa + sb + longint'(ci);
        ov   = (r >= half) || (r < -half);
        return {ov, (full >= m) ? 1'b1 : 1'b0, 32'(full % m)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            e_sum[i] = '0; e_cout[i] = 1'b0; e_ovf[i] = 1'b0; e_vld[i] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld4"}, if4.out_valid, 0);
        chk({tag, "_res4"}, {if4.cout, if4.sum}, 0);
        chk({tag, "_vld16"}, if16.out_valid, 0);
        chk({tag, "_res16"}, {if16.cout, if16.sum}, 0);
`ifdef CLA_OVERFLOW_EN
        chk({tag, "_ovf4"}, if4.ovf, 0);
        chk({tag, "_ovf16"}, if16.ovf, 0);
`endif
    endtask

    // Update the model from the inputs about to be captured, cross one edge,
    // then compare both instances
    task automatic step();
        logic [33:0] r;
        if (if4.in_valid) begin
            r = ref_add(4, if4.a, if4.b, if4.cin);
            e_sum[0] = r[31:0]; e_cout[0] = r[32]; e_ovf[0] = r[33];
        end
        e_vld[0] = if4.in_valid;
        if (if16.in_valid) begin
            r = ref_add(16, if16.a, if16.b, if16.cin);
            e_sum[1] = r[31:0]; e_cout[1] = r[32]; e_ovf[1] = r[33];
        end
        e_vld[1] = if16.in_valid;
        @(posedge clk);
        #1;
        chk("vld4", if4.out_valid, e_vld[0]);
        chk("res4", {if4.cout, if4.sum}, {e_cout[0], e_sum[0][3:0]});
        chk("vld16", if16.out_valid, e_vld[1]);
        chk("res16", {if16.cout, if16.sum}, {e_cout[1], e_sum[1][15:0]});
`ifdef CLA_OVERFLOW_EN
        chk("ovf4", if4.ovf, e_ovf[0]);
        chk("ovf16", if16.ovf, e_ovf[1]);
`endif
    endtask

    initial begin
        vecs[0] = '{a: 4'h1, b: 4'h0, cin: 1'b0, s: 4'h1, co: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 4'h2, b: 4'h4, cin: 1'b1, s: 4'h7, co: 1'b0, ov: 1'b0};
        vecs[2] = '{a: 4'hB, b: 4'h5, cin: 1'b0, s: 4'h0, co: 1'b1, ov: 1'b0};
        vecs[3] = '{a: 4'h5, b: 4'h3, cin: 1'b1, s: 4'h9, co: 1'b0, ov: 1'b1};

        rst_n = 1'b0;
        if4.in_valid = 0;  if4.a = '0;  if4.b = '0;  if4.cin = 0;
        if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.cin = 0;
        model_clear();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, applied back-to-back
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1; if4.a = vecs[i].a; if4.b = vecs[i].b; if4.cin = vecs[i].cin;
            step();
            chk($sformatf("vec%0d_sum", i), if4.sum, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), if4.cout, vecs[i].co);
            chk($sformatf("vec%0d_vld", i), if4.out_valid, 1);
`ifdef CLA_OVERFLOW_EN
            chk($sformatf("vec%0d_ovf", i), if4.ovf, vecs[i].ov);
`endif
        end

        // in_valid low: out_valid drops, result holds at 9 despite new operands
        for (int i = 0; i < 2; i++) begin
            if4.in_valid = 1'b0; if4.a = 4'hF; if4.b = 4'hF; if4.cin = 1'b1;
            step();
            chk("hold_vld", if4.out_valid, 0);
            chk("hold_sum", if4.sum, 4'h9);
        end

        // Full-length carry propagate through all 16-bit groups
        if16.in_valid = 1'b1; if16.a = 16'hFFFF; if16.b = 16'h0000; if16.cin = 1'b1;
        step();
        chk("prop16_sum", if16.sum, 16'h0000);
        chk("prop16_cout", if16.cout, 1);
        if16.in_valid = 1'b0;

        // Mid-stream async reset discards the in-flight operands
        if4.in_valid = 1'b1;  if4.a = 4'h1;  if4.b = 4'h2;  if4.cin = 1'b0;
        if16.in_valid = 1'b1; if16.a = 16'h1234; if16.b = 16'h0001; if16.cin = 1'b0;
        step();
        if4.a = 4'h7; if4.b = 4'h7; if16.a = 16'hABCD; if16.b = 16'h1111;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        if4.in_valid = 1'b0; if16.in_valid = 1'b0;
        step();
        chk("post_rst_sum4", if4.sum, 0);
        // First capture after release
        if4.in_valid = 1'b1; if4.a = 4'h3; if4.b = 4'h4; if4.cin = 1'b0;
        step();
        chk("post_rst_cap4", if4.sum, 4'h7);

        // Exhaustive 4-bit sweep, random 16-bit traffic with gaps
        for (int i = 0; i < 512; i++) begin
            if4.in_valid = 1'b1;
            if4.a = i[3:0]; if4.b = i[7:4]; if4.cin = i[8];
            if16.in_valid = ($urandom_range(0, 3) != 0);
            if16.a   = 16'($urandom);
            if16.b   = ($urandom_range(0, 7) == 0) ? ~if16.a : 16'($urandom);
            if16.cin = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
